// File: rtl/grf_wb_ctrl.sv
// GRF write-port controller: merges W-stage writeback with queued slow-unit results
// and tracks which registers are still owed by the slow unit.
module grf_wb_ctrl #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [4:0]        pipe_a3,
    input  logic [DATA_W-1:0] pipe_wd,
    input  logic [DATA_W-1:0] pipe_pc,
    input  logic              slow_valid,
    output logic              slow_ready,
    input  logic [4:0]        slow_a3,
    input  logic [DATA_W-1:0] slow_wd,
    input  logic [DATA_W-1:0] slow_pc,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [4:0]        issue_a3,
    input  logic [4:0]        q_a1,
    input  logic [4:0]        q_a2,
    output logic              q_busy1,
    output logic              q_busy2,
    output logic              grf_we,
    output logic [4:0]        grf_a3,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [4:0]        fifo_a3 [DEPTH];
    logic [DATA_W-1:0] fifo_wd [DEPTH];
    logic [DATA_W-1:0] fifo_pc [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic [31:0]       pending;
    logic [31:0]       pending_nxt;

    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              pipe_claim;
    logic              issue_fire;
    logic [4:0]        head_a3;
    logic [DATA_W-1:0] head_wd;
    logic [DATA_W-1:0] head_pc;

    assign fifo_empty  = (count == '0);
    assign slow_ready  = (count != FULL_CNT);
    assign push        = slow_valid && slow_ready;
    assign pipe_claim  = pipe_we && (pipe_a3 != 5'd0);
    // The FIFO drains only into cycles the pipeline leaves free, including $0 writes.
    assign pop         = !fifo_empty && !pipe_claim;

    assign head_a3     = fifo_a3[rd_ptr];
    assign head_wd     = fifo_wd[rd_ptr];
    assign head_pc     = fifo_pc[rd_ptr];

    assign issue_ready = !pending[issue_a3] || (issue_a3 == 5'd0);
    assign issue_fire  = issue_valid && issue_ready && (issue_a3 != 5'd0);
    assign q_busy1     = pending[q_a1] && (q_a1 != 5'd0);
    assign q_busy2     = pending[q_a2] && (q_a2 != 5'd0);

    // A same-edge issue to the register being retired must leave it pending.
    always_comb begin
        pending_nxt = pending;
        if (pop && (head_a3 != 5'd0)) begin
            pending_nxt[head_a3] = 1'b0;
        end
        if (issue_fire) begin
            pending_nxt[issue_a3] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // FIFO storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a3[wr_ptr] <= slow_a3;
            fifo_wd[wr_ptr] <= slow_wd;
            fifo_pc[wr_ptr] <= slow_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pending <= '0;
            grf_we  <= 1'b0;
            grf_a3  <= '0;
            grf_wd  <= '0;
            grf_pc  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            pending <= pending_nxt;

            // Write-port stage: pipeline first, then FIFO head, else idle with held payload.
            if (pipe_claim) begin
                grf_we <= 1'b1;
                grf_a3 <= pipe_a3;
                grf_wd <= pipe_wd;
                grf_pc <= pipe_pc;
            end else if (pop && (head_a3 != 5'd0)) begin
                grf_we <= 1'b1;
                grf_a3 <= head_a3;
                grf_wd <= head_wd;
                grf_pc <= head_pc;
            end else begin
                grf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_grf_wb_ctrl.sv
// Randomized and directed bench for grf_wb_ctrl against a queue-based reference model.
module tb_grf_wb_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        slow_valid;
    logic        slow_ready;
    logic [4:0]  slow_a3;
    logic [31:0] slow_wd;
    logic [31:0] slow_pc;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_a3;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        q_busy1;
    logic        q_busy2;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    always #5 clk = ~clk;

    grf_wb_ctrl #(.DEPTH(4), .PTR_W(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
        .slow_valid(slow_valid), .slow_ready(slow_ready),
        .slow_a3(slow_a3), .slow_wd(slow_wd), .slow_pc(slow_pc),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_a3(issue_a3),
        .q_a1(q_a1), .q_a2(q_a2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
    );

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    bit [31:0]   pend_m;
    bit          exp_we;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;
    logic [31:0] exp_pc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; pipe_we = 1'b0; pipe_a3 = '0; pipe_wd = '0; pipe_pc = '0;
        slow_valid = 1'b0; slow_a3 = '0; slow_wd = '0; slow_pc = '0;
        issue_valid = 1'b0; issue_a3 = '0; q_a1 = '0; q_a2 = '0;
    endtask

    // Called at the falling edge with inputs already driven; checks the combinational
    // outputs, advances the model across one rising edge and checks the write port.
    task automatic cycle();
        ent_t h;
        bit   rdy;
        bit   irdy;
        #1;
        rdy  = (mq.size() < DEPTH);
        irdy = (issue_a3 == 5'd0) || !pend_m[issue_a3];
        chk("slow_ready", slow_ready, rdy);
        chk("issue_ready", issue_ready, irdy);
        chk("q_busy1", q_busy1, (q_a1 != 5'd0) && pend_m[q_a1]);
        chk("q_busy2", q_busy2, (q_a2 != 5'd0) && pend_m[q_a2]);
        if (rst) begin
            mq.delete();
            pend_m = '0;
            exp_we = 1'b0; exp_a3 = '0; exp_wd = '0; exp_pc = '0;
        end else begin
            if (pipe_we && pipe_a3 != 5'd0) begin
                exp_we = 1'b1; exp_a3 = pipe_a3; exp_wd = pipe_wd; exp_pc = pipe_pc;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.a3 != 5'd0) begin
                    exp_we = 1'b1; exp_a3 = h.a3; exp_wd = h.wd; exp_pc = h.pc;
                    pend_m[h.a3] = 1'b0;
                end else begin
                    exp_we = 1'b0;
                end
            end else begin
                exp_we = 1'b0;
            end
            if (slow_valid && rdy) begin
                h.a3 = slow_a3; h.wd = slow_wd; h.pc = slow_pc;
                mq.push_back(h);
            end
            if (issue_valid && irdy && issue_a3 != 5'd0) pend_m[issue_a3] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("grf_we", grf_we, exp_we);
        if (exp_we || rst) begin
            chk("grf_a3", grf_a3, exp_a3);
            chk("grf_wd", grf_wd, exp_wd);
            chk("grf_pc", grf_pc, exp_pc);
        end
        @(negedge clk);
    endtask

    task automatic push_slow(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        slow_valid = 1'b1; slow_a3 = a3; slow_wd = wd; slow_pc = pc;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        chk("rst_we", grf_we, 1'b0);
        chk("rst_wd", grf_wd, 32'h0);
        chk("rst_ready", slow_ready, 1'b1);

        // Pipeline write lands on the next edge.
        pipe_we = 1'b1; pipe_a3 = 5'd5; pipe_wd = 32'h1234; pipe_pc = 32'h3000;
        cycle();
        chk("t1_we", grf_we, 1'b1);
        chk("t1_a3", grf_a3, 5'd5);
        chk("t1_wd", grf_wd, 32'h1234);
        chk("t1_pc", grf_pc, 32'h3000);

        // Issue to $8, then the slow result retires it two edges after its push.
        idle(); issue_valid = 1'b1; issue_a3 = 5'd8; q_a1 = 5'd8;
        cycle();
        chk("t2_busy_set", q_busy1, 1'b1);
        idle(); q_a1 = 5'd8; push_slow(5'd8, 32'hABCD, 32'h3004);
        cycle();
        chk("t2_not_yet", grf_we, 1'b0);
        idle(); q_a1 = 5'd8;
        cycle();
        chk("t2_we", grf_we, 1'b1);
        chk("t2_wd", grf_wd, 32'hABCD);
        chk("t2_busy_clr", q_busy1, 1'b0);

        // Fill the FIFO while the pipeline owns the port, then drain in order.
        for (int i = 0; i < 5; i++) begin
            idle(); pipe_we = 1'b1; pipe_a3 = 5'(1 + i); pipe_wd = 32'h100 + i; pipe_pc = 32'h4000 + 4 * i;
            push_slow(5'(16 + i), 32'h5000 + i, 32'h6000 + 4 * i);
            cycle();
        end
        chk("t3_full", slow_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle();
            cycle();
        end
        chk("t3_drained", slow_ready, 1'b1);

        // A $0 pipe write leaves the port to the FIFO head; a $0 slow entry writes nothing.
        idle(); push_slow(5'd3, 32'h3333, 32'h7000);
        cycle();
        idle(); pipe_we = 1'b1; pipe_a3 = 5'd0; pipe_wd = 32'hFFFF;
        cycle();
        chk("t4_head_a3", grf_a3, 5'd3);
        chk("t4_head_wd", grf_wd, 32'h3333);
        idle(); push_slow(5'd0, 32'h0BAD, 32'h7004);
        cycle();
        idle();
        cycle();
        chk("t4_zero_we", grf_we, 1'b0);

        // Reset drops queued writes and pending marks.
        for (int i = 0; i < 3; i++) begin
            idle(); issue_valid = 1'b1; issue_a3 = 5'(10 + i);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            idle(); pipe_we = 1'b1; pipe_a3 = 5'd1; pipe_wd = 32'h77; push_slow(5'(10 + i), 32'h8000 + i, 32'h0);
            cycle();
        end
        idle(); rst = 1'b1;
        cycle();
        idle(); q_a1 = 5'd10; q_a2 = 5'd11;
        chk("t5_ready", slow_ready, 1'b1);
        chk("t5_busy1", q_busy1, 1'b0);
        chk("t5_busy2", q_busy2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(); q_a1 = 5'd12;
            cycle();
            chk("t5_no_write", grf_we, 1'b0);
        end

        // Same-edge retire and issue of $9 keeps it pending.
        idle(); push_slow(5'd9, 32'h9999, 32'h9000);
        cycle();
        idle(); issue_valid = 1'b1; issue_a3 = 5'd9; q_a1 = 5'd9;
        cycle();
        chk("t6_we", grf_we, 1'b1);
        chk("t6_busy", q_busy1, 1'b1);

        // Back-to-back push/pop pairs wrap the pointers several times.
        for (int i = 0; i < 10; i++) begin
            idle(); push_slow(5'(20 + (i % 8)), 32'hA000 + i, 32'hB000 + 4 * i);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            cycle();
        end

        // Random traffic, small register range to provoke collisions, rare resets.
        for (int n = 0; n < 600; n++) begin
            idle();
            rst         = ($urandom_range(0, 99) == 0);
            pipe_we     = ($urandom_range(0, 9) < 4);
            pipe_a3     = 5'($urandom_range(0, 7));
            pipe_wd     = $urandom;
            pipe_pc     = $urandom;
            slow_valid  = ($urandom_range(0, 9) < 5);
            slow_a3     = 5'($urandom_range(0, 7));
            slow_wd     = $urandom;
            slow_pc     = $urandom;
            issue_valid = ($urandom_range(0, 9) < 4);
            issue_a3    = 5'($urandom_range(0, 7));
            q_a1        = 5'($urandom_range(0, 7));
            q_a2        = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
